// File: rtl/uart_rx_word_if.sv
// Memory-mapped load port between the SoC bus and the UART receive word register.
interface uart_rx_word_if;
    logic        re;
    logic [31:0] address;
    logic [31:0] dataOut;

    modport master (output re, output address, input dataOut);
    modport slave  (input re, input address, output dataOut);
endinterface

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs four bytes (LSB first) into a 32-bit word,
// read back through a memory-mapped load port; framing/overrun flags are sticky.
module uart_rx_word #(
    parameter int          CLKS_PER_BIT = 87,
    parameter logic [31:0] RX_ADDR      = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            serial,
    uart_rx_word_if.slave   bus,
    output logic            o_Rx_Valid,
    output logic            o_Rx_Byte_Done,
    output logic            o_Frame_Err,
    output logic            o_Overrun
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    idx_reg;
    logic [1:0]    k_reg;
    logic [7:0]    byte_sr;
    // Top byte of a word is never buffered: it goes straight into hold.
    logic [23:0]   word_sr;
    logic [31:0]   hold_reg;
    logic          sync1_reg;
    logic          rx_s;

    logic bit_tick;
    logic read_hit;
    logic stop_good;
    logic stop_bad;
    logic word_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync1_reg <= serial;
            rx_s      <= sync1_reg;
        end
    end

    always_comb begin
        bit_tick  = (cnt_reg == LAST);
        read_hit  = bus.re && (bus.address == RX_ADDR);
        stop_good = (state_reg == STOP) && bit_tick && rx_s;
        stop_bad  = (state_reg == STOP) && bit_tick && !rx_s;
        word_done = stop_good && (k_reg == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            k_reg          <= '0;
            byte_sr        <= '0;
            word_sr        <= '0;
            hold_reg       <= '0;
            bus.dataOut    <= '0;
            o_Rx_Valid     <= 1'b0;
            o_Rx_Byte_Done <= 1'b0;
            o_Frame_Err    <= 1'b0;
            o_Overrun      <= 1'b0;
        end else begin
            o_Rx_Byte_Done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    idx_reg <= '0;
                    if (!rx_s) state_reg <= START;
                end
                START: begin
                    if (cnt_reg == HALF) begin
                        cnt_reg   <= '0;
                        state_reg <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        cnt_reg          <= '0;
                        byte_sr[idx_reg] <= rx_s;
                        idx_reg          <= idx_reg + 3'd1;
                        if (idx_reg == 3'd7) state_reg <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        cnt_reg   <= '0;
                        state_reg <= CLEANUP;
                        if (rx_s) begin
                            o_Rx_Byte_Done <= 1'b1;
                            if (k_reg != 2'd3) word_sr[{k_reg, 3'b000} +: 8] <= byte_sr;
                            k_reg <= k_reg + 2'd1;
                        end else begin
                            k_reg <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CLEANUP: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            // A read returns the pre-update hold even when a word lands in the same cycle.
            if (read_hit) bus.dataOut <= hold_reg;

            if (word_done && (!o_Rx_Valid || read_hit)) begin
                hold_reg   <= {byte_sr, word_sr};
                o_Rx_Valid <= 1'b1;
            end else if (read_hit) begin
                o_Rx_Valid <= 1'b0;
            end

            if (word_done && o_Rx_Valid && !read_hit) o_Overrun <= 1'b1;
            else if (read_hit)                         o_Overrun <= 1'b0;

            if (stop_bad)      o_Frame_Err <= 1'b1;
            else if (read_hit) o_Frame_Err <= 1'b0;
        end
    end
endmodule
